// File: rtl/sm_gpio_irq.sv
// GPIO slave for the schoolMIPS bus: per-pin direction, synchronised and debounced inputs, edge interrupts.
// Latency: writes take effect on the next clk edge; reads are combinational; an input change reaches IN
// SYNC_STAGES+DEBOUNCE_CYCLES edges after first sampling; irq follows STATUS/IRQ_EN by one edge. No backpressure.
// Optional: define SM_GPIO_ATOMIC_EN to add write-only OUT_SET (addr 6) and OUT_CLR (addr 7) registers.
module sm_gpio_irq #(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bSel,
    input  logic [31:0]      bAddr,
    input  logic             bWrite,
    input  logic [31:0]      bWData,
    output logic [31:0]      bRData,
    input  logic [WIDTH-1:0] gpioInput,
    output logic [WIDTH-1:0] gpioOutput,
    output logic [WIDTH-1:0] gpioOutEn,
    output logic             irq
);

    // Counter only needs to reach DEBOUNCE_CYCLES-1.
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [2:0] A_IN     = 3'd0;
    localparam logic [2:0] A_OUT    = 3'd1;
    localparam logic [2:0] A_DIR    = 3'd2;
    localparam logic [2:0] A_IRQEN  = 3'd3;
    localparam logic [2:0] A_POL    = 3'd4;
    localparam logic [2:0] A_STATUS = 3'd5;
`ifdef SM_GPIO_ATOMIC_EN
    localparam logic [2:0] A_SET    = 3'd6;
    localparam logic [2:0] A_CLR    = 3'd7;
`endif

    // Bus decode
    logic [2:0]       addr;
    logic             wr_en;
    logic [WIDTH-1:0] wdat;
    logic             unused_bits;

    assign addr        = bAddr[4:2];
    assign wr_en       = bSel & bWrite;
    assign wdat        = bWData[WIDTH-1:0];
    // Undecoded address bits and write-data bits above WIDTH are intentionally ignored.
    assign unused_bits = ^{bAddr[31:5], bAddr[1:0], bWData};

    // Software-visible registers
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] dir_q, dir_d;
    logic [WIDTH-1:0] irqen_q, irqen_d;
    logic [WIDTH-1:0] pol_q, pol_d;
    logic [WIDTH-1:0] status_q, status_d;
    logic             irq_q, irq_d;

    // Input path state
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
    logic [WIDTH-1:0]                  synced;
    logic [WIDTH-1:0]                  stable_q, stable_d;
    logic [WIDTH-1:0][CNT_W-1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0]                  rise, fall, evt, w1c;

    // Shift raw pins through the synchroniser chain; the last stage is the usable value.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], gpioInput};
    end

    assign synced = sync_q[SYNC_STAGES-1];

    // Per-pin debounce: count cycles the synchronised value disagrees with stable, accept at the limit.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (synced[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                stable_d[i] = synced[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Edge events are taken from the stable value as it updates, so STATUS sets on the same edge.
    always_comb begin
        rise = stable_d & ~stable_q;
        fall = ~stable_d & stable_q;
        evt  = (rise & ~pol_q) | (fall & pol_q);
    end

    // Register writes; STATUS is write-1-to-clear with a concurrent event taking priority.
    always_comb begin
        out_d   = out_q;
        dir_d   = dir_q;
        irqen_d = irqen_q;
        pol_d   = pol_q;
        w1c     = '0;
        if (wr_en) begin
            case (addr)
                A_OUT:    out_d   = wdat;
                A_DIR:    dir_d   = wdat;
                A_IRQEN:  irqen_d = wdat;
                A_POL:    pol_d   = wdat;
                A_STATUS: w1c     = wdat;
`ifdef SM_GPIO_ATOMIC_EN
                A_SET:    out_d   = out_q | wdat;
                A_CLR:    out_d   = out_q & ~wdat;
`endif
                default:  ;
            endcase
        end
        status_d = (status_q & ~w1c) | evt;
        irq_d    = |(status_q & irqen_q);
    end

    // State registers, all cleared by reset (stable starts low, so pins high at reset raise an event).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q    <= '0;
            dir_q    <= '0;
            irqen_q  <= '0;
            pol_q    <= '0;
            status_q <= '0;
            irq_q    <= 1'b0;
            sync_q   <= '0;
            stable_q <= '0;
            cnt_q    <= '0;
        end else begin
            out_q    <= out_d;
            dir_q    <= dir_d;
            irqen_q  <= irqen_d;
            pol_q    <= pol_d;
            status_q <= status_d;
            irq_q    <= irq_d;
            sync_q   <= sync_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    // Read mux returns register contents (never the pins); unused addresses read zero.
    always_comb begin
        bRData = '0;
        case (addr)
            A_IN:     bRData = 32'(stable_q);
            A_OUT:    bRData = 32'(out_q);
            A_DIR:    bRData = 32'(dir_q);
            A_IRQEN:  bRData = 32'(irqen_q);
            A_POL:    bRData = 32'(pol_q);
            A_STATUS: bRData = 32'(status_q);
            default:  bRData = '0;
        endcase
    end

    assign gpioOutput = out_q;
    assign gpioOutEn  = dir_q;
    assign irq        = irq_q;

endmodule

// File: tb/tb_sm_gpio_irq.sv
// Directed bench for sm_gpio_irq with WIDTH=8, SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Expected values are hand-computed constants.
module tb_sm_gpio_irq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        bSel = 1'b0;
    logic [31:0] bAddr = '0;
    logic        bWrite = 1'b0;
    logic [31:0] bWData = '0;
    logic [31:0] bRData;
    logic [7:0]  gpioInput = '0;
    logic [7:0]  gpioOutput;
    logic [7:0]  gpioOutEn;
    logic        irq;

    int n_checks = 0;
    int n_pass   = 0;

    sm_gpio_irq #(
        .WIDTH(8),
        .SYNC_STAGES(2),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bSel(bSel),
        .bAddr(bAddr),
        .bWrite(bWrite),
        .bWData(bWData),
        .bRData(bRData),
        .gpioInput(gpioInput),
        .gpioOutput(gpioOutput),
        .gpioOutEn(gpioOutEn),
        .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
        bSel   = 1'b1;
        bWrite = 1'b1;
        bAddr  = {27'd0, a, 2'b00};
        bWData = d;
        tick(1);
        bSel   = 1'b0;
        bWrite = 1'b0;
        bWData = '0;
    endtask

    task automatic rd_check(input string tag, input logic [2:0] a, input logic [31:0] exp);
        bAddr = {27'd0, a, 2'b00};
        #1;
        check(tag, bRData, exp);
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_gpioOutput", {24'd0, gpioOutput}, 32'h0);
        check("rst_gpioOutEn", {24'd0, gpioOutEn}, 32'h0);
        check("rst_irq", {31'd0, irq}, 32'h0);
        for (int a = 0; a < 8; a++) rd_check($sformatf("rst_rd_addr%0d", a), 3'(a), 32'h0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        tick(1);

        // OUT / DIR registers and pin drive
        bus_wr(3'd1, 32'h0000_00A5);
        bus_wr(3'd2, 32'h0000_000F);
        check("gpioOutput_A5", {24'd0, gpioOutput}, 32'hA5);
        check("gpioOutEn_0F", {24'd0, gpioOutEn}, 32'h0F);
        rd_check("rd_out_A5", 3'd1, 32'hA5);
        rd_check("rd_dir_0F", 3'd2, 32'h0F);
        bus_wr(3'd1, 32'hFFFF_FF00);
        rd_check("rd_out_upper_ignored", 3'd1, 32'h00);
        check("gpioOutput_00", {24'd0, gpioOutput}, 32'h00);

        // Pin0 rising: IN/STATUS update 6 edges after first sample, irq one edge later
        bus_wr(3'd3, 32'h01);
        gpioInput = 8'h01;
        tick(5);
        rd_check("in_pin0_edge5", 3'd0, 32'h00);
        rd_check("status_edge5", 3'd5, 32'h00);
        tick(1);
        rd_check("in_pin0_edge6", 3'd0, 32'h01);
        rd_check("status_edge6", 3'd5, 32'h01);
        check("irq_edge6", {31'd0, irq}, 32'h0);
        tick(1);
        check("irq_edge7", {31'd0, irq}, 32'h1);

        // W1C clears STATUS, irq drops one edge later
        bus_wr(3'd5, 32'h01);
        rd_check("status_cleared", 3'd5, 32'h00);
        check("irq_after_clear_edge", {31'd0, irq}, 32'h1);
        tick(1);
        check("irq_dropped", {31'd0, irq}, 32'h0);

        // Falling edge with rising polarity: no event
        gpioInput = 8'h00;
        tick(8);
        rd_check("in_pin0_fell", 3'd0, 32'h00);
        rd_check("status_no_fall_evt", 3'd5, 32'h00);
        check("irq_no_fall_evt", {31'd0, irq}, 32'h0);

        // Three-cycle glitch on pin1 is rejected
        gpioInput = 8'h02;
        tick(3);
        gpioInput = 8'h00;
        tick(10);
        rd_check("in_glitch", 3'd0, 32'h00);
        rd_check("status_glitch", 3'd5, 32'h00);

        // Pin2 event coincident with W1C of bit2: set wins; IRQ_EN[2]=0 keeps irq low
        gpioInput = 8'h04;
        tick(5);
        bus_wr(3'd5, 32'h04);
        rd_check("in_pin2", 3'd0, 32'h04);
        rd_check("status_set_wins", 3'd5, 32'h04);
        tick(1);
        check("irq_masked", {31'd0, irq}, 32'h0);
        bus_wr(3'd3, 32'h05);
        check("irq_enable_edge", {31'd0, irq}, 32'h0);
        tick(1);
        check("irq_unmasked", {31'd0, irq}, 32'h1);
        bus_wr(3'd5, 32'h04);
        tick(1);
        check("irq_pin2_cleared", {31'd0, irq}, 32'h0);

        // Polarity change creates no event; later falling edge on pin2 does
        bus_wr(3'd4, 32'h04);
        tick(2);
        rd_check("pol_change_no_evt", 3'd5, 32'h00);
        rd_check("rd_pol", 3'd4, 32'h04);
        gpioInput = 8'h00;
        tick(5);
        rd_check("fall_evt_edge5", 3'd5, 32'h00);
        tick(1);
        rd_check("fall_evt_edge6", 3'd5, 32'h04);
        bus_wr(3'd5, 32'h04);
        bus_wr(3'd3, 32'h00);

        // Atomic set/clear registers (or ignored writes when not built in)
        bus_wr(3'd1, 32'h0F);
        bus_wr(3'd6, 32'h30);
`ifdef SM_GPIO_ATOMIC_EN
        rd_check("out_after_set", 3'd1, 32'h3F);
`else
        rd_check("out_after_set", 3'd1, 32'h0F);
`endif
        bus_wr(3'd7, 32'h03);
`ifdef SM_GPIO_ATOMIC_EN
        rd_check("out_after_clr", 3'd1, 32'h3C);
`else
        rd_check("out_after_clr", 3'd1, 32'h0F);
`endif
        rd_check("rd_addr6", 3'd6, 32'h00);
        rd_check("rd_addr7", 3'd7, 32'h00);

        // Reset mid-debounce discards the count; pin high at reset raises an event after release
        gpioInput = 8'h80;
        tick(3);
        rst_n = 1'b0;
        #2;
        rd_check("midrst_in", 3'd0, 32'h00);
        rd_check("midrst_out", 3'd1, 32'h00);
        check("midrst_irq", {31'd0, irq}, 32'h0);
        #1;
        rst_n = 1'b1;
        tick(5);
        rd_check("post_rst_edge5", 3'd0, 32'h00);
        tick(1);
        rd_check("post_rst_in_edge6", 3'd0, 32'h80);
        rd_check("post_rst_status", 3'd5, 32'h80);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
